// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and word type for the RAM hierarchy
//   WORD_W    data width of every RAM level
//   RAM8_AW   address width of one 8-word bank
//   RAM64_AW  address width of the 64-word level
//   word_t    one memory word
package ram_pkg;
   localparam int WORD_W   = 16;
   localparam int RAM8_AW  = 3;
   localparam int RAM64_AW = 6;
   localparam int RAM8_N   = 1 << RAM8_AW;
   localparam int BANKS_64 = 1 << (RAM64_AW - RAM8_AW);
   typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/ram8.sv
// ram8: 8 x 16 register bank, combinational read, synchronous write
//   clock    write clock (rising edge)
//   reset_n  async active-low clear of all words
//   in       write data
//   address  word select 0-7
//   load     write enable sampled on the rising edge
//   out      contents of the selected word
module ram8
   import ram_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  word_t              in,
   input  logic [RAM8_AW-1:0] address,
   input  logic               load,
   output word_t              out
);
   word_t mem_q [RAM8_N];
   word_t mem_d [RAM8_N];
   always_comb begin
      mem_d = mem_q;
      if (load) mem_d[address] = in;
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) mem_q <= '{default: '0};
      else mem_q <= mem_d;
   assign out = mem_q[address];
endmodule

// File: rtl/ram64.sv
// ram64: 64 x 16 RAM built from eight ram8 banks
//   clock    write clock (rising edge)
//   reset_n  async active-low clear of all words
//   in       write data
//   address  word select 0-63; [5:3] bank, [2:0] word in bank
//   load     write enable sampled on the rising edge
//   out      contents of the selected word
module ram64
   import ram_pkg::*;
(
   input  logic                clock,
   input  logic                reset_n,
   input  word_t               in,
   input  logic [RAM64_AW-1:0] address,
   input  logic                load,
   output word_t               out
);
   logic [RAM64_AW-RAM8_AW-1:0] bank;
   word_t                       bank_out [BANKS_64];
   assign bank = address[RAM64_AW-1:RAM8_AW];
   for (genvar b = 0; b < BANKS_64; b++) begin : g_bank
      ram8 u_ram8 (
         .clock   (clock),
         .reset_n (reset_n),
         .in      (in),
         .address (address[RAM8_AW-1:0]),
         .load    (load && bank == (RAM64_AW-RAM8_AW)'(b)),
         .out     (bank_out[b])
      );
   end
   assign out = bank_out[bank];
endmodule

// File: tb/tb_ram64.sv
// tb_ram64: directed self-checking bench for ram64 against an array model
module tb_ram64;
   import ram_pkg::*;
   logic        clock = 0;
   logic        reset_n = 0;
   word_t       in = '0;
   logic [5:0]  address = '0;
   logic        load = 0;
   word_t       out;
   word_t       model [64] = '{default: '0};
   int          n_chk = 0;
   int          n_fail = 0;

   ram64 dut (
      .clock   (clock),
      .reset_n (reset_n),
      .in      (in),
      .address (address),
      .load    (load),
      .out     (out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input word_t act, input word_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s addr=%0d got=%h expected=%h @%0t", name, address, act, exp, $time);
      end
   endtask

   // memory model: plain array of words
   always @(posedge clock or negedge reset_n)
      if (!reset_n) foreach (model[i]) model[i] = '0;
      else if (load) model[address] = in;

   always @(negedge clock)
      if (reset_n) chk("model", out, model[address]);

   task automatic rd(input string name, input int a, input word_t exp);
      address = 6'(a);
      #1 chk(name, out, exp);
   endtask

   task automatic wr(input int a, input word_t d);
      @(negedge clock); #1;
      address = 6'(a); in = d; load = 1;
      @(negedge clock); #1;
      load = 0;
   endtask

   initial begin
      repeat (2) @(negedge clock);
      #1 reset_n = 1;
      for (int b = 0; b < 8; b++) rd("reset_bank", b * 8, 16'h0000);
      rd("reset_63", 63, 16'h0000);

      wr(16, 16'd15);
      for (int b = 0; b < 8; b++) rd("isolation", b * 8, (b == 2) ? 16'd15 : 16'h0000);
      rd("isolation_63", 63, 16'h0000);

      @(negedge clock); #1;
      address = 6'd5; in = 16'hBEEF; load = 0;
      repeat (3) @(posedge clock);
      #1 chk("load_low", out, 16'h0000);

      @(negedge clock); #1;
      address = 6'd16; load = 1; in = 16'h1234;
      #1 chk("rdw_before", out, 16'd15);
      @(posedge clock); #1;
      chk("rdw_after", out, 16'h1234);
      load = 0;

      for (int a = 0; a < 64; a++) wr(a, word_t'(a * 3 + 1));
      for (int a = 0; a < 64; a++) rd("sweep", a, word_t'(a * 3 + 1));
      rd("sweep_0", 0, 16'd1);
      rd("sweep_63", 63, 16'd190);

      wr(63, 16'hFFFF);
      @(negedge clock); #1;
      address = 6'd63; in = 16'hAAAA; load = 1;
      #1 chk("pre_reset", out, 16'hFFFF);
      #1 reset_n = 0;
      #1 chk("async_reset", out, 16'h0000);
      @(posedge clock); #1;
      chk("write_dropped", out, 16'h0000);
      load = 0; reset_n = 1;
      rd("after_reset_63", 63, 16'h0000);
      rd("after_reset_0", 0, 16'h0000);
      rd("after_reset_16", 16, 16'h0000);

      wr(40, 16'h5A5A);
      rd("post_reset_write", 40, 16'h5A5A);
      rd("post_reset_nb", 41, 16'h0000);
      repeat (2) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
